vedic_mult_seq_ctrl: RTL and testbench

Sequencing controller that computes a 16x16 unsigned product by reusing one 8x8 Vedic multiplier over four cycles.
- Each cycle it drives one pair of operand bytes into the shared multiplier.
- It accumulates the shifted partial products into a 32-bit register.
- It presents the result with a valid/ready handshake.
- It sits between an upstream operand source and any downstream consumer that needs wide products without the area of a full-width multiplier array.

---
 rtl/vedic_mult_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_vedic_mult_seq_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/vedic_mult_seq_ctrl.sv
// Sequential 16x16 unsigned multiplier: one combinational 8x8 Vedic core
// reused over four cycles, with valid/ready handshakes on both sides.
module vedic_mult_seq_ctrl #(
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] product,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [31:0] acc_q, acc_d, product_q, product_d;
  logic        out_valid_q, out_valid_d;

  logic [7:0]  mul_a, mul_b;
  logic [15:0] pp;
  logic [31:0] pp_shifted, acc_sum;

  // Urdhva-Tiryagbhyam building block: 2x2 from AND gates and half adders.
  function automatic logic [3:0] vm2(input logic [1:0] x, input logic [1:0] y);
    logic [3:0] p;
    logic       c;
    p[0] = x[0] & y[0];
    p[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
    c    = (x[1] & y[0]) & (x[0] & y[1]);
    p[2] = (x[1] & y[1]) ^ c;
    p[3] = (x[1] & y[1]) & c;
    return p;
  endfunction

  function automatic logic [7:0] vm4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] ll, lh, hl, hh;
    ll = vm2(x[1:0], y[1:0]);
    lh = vm2(x[3:2], y[1:0]);
    hl = vm2(x[1:0], y[3:2]);
    hh = vm2(x[3:2], y[3:2]);
    return {4'd0, ll} + {2'd0, lh, 2'd0} + {2'd0, hl, 2'd0} + {hh, 4'd0};
  endfunction

  function automatic logic [15:0] vm8(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] ll, lh, hl, hh;
    ll = vm4(x[3:0], y[3:0]);
    lh = vm4(x[7:4], y[3:0]);
    hl = vm4(x[3:0], y[7:4]);
    hh = vm4(x[7:4], y[7:4]);
    return {8'd0, ll} + {4'd0, lh, 4'd0} + {4'd0, hl, 4'd0} + {hh, 8'd0};
  endfunction

  // Operand byte selection and partial-product alignment per step
  always_comb begin
    mul_a      = a_q[7:0];
    mul_b      = b_q[7:0];
    pp_shifted = 32'd0;
    case (step_q)
      2'd0: begin mul_a = a_q[7:0];  mul_b = b_q[7:0];  end
      2'd1: begin mul_a = a_q[15:8]; mul_b = b_q[7:0];  end
      2'd2: begin mul_a = a_q[7:0];  mul_b = b_q[15:8]; end
      default: begin mul_a = a_q[15:8]; mul_b = b_q[15:8]; end
    endcase
    pp = vm8(mul_a, mul_b);
    case (step_q)
      2'd0:    pp_shifted = {16'd0, pp};
      2'd1,
      2'd2:    pp_shifted = {8'd0, pp, 8'd0};
      default: pp_shifted = {pp, 16'd0};
    endcase
    acc_sum = acc_q + pp_shifted;
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    product_d   = product_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d   = a;
          b_d   = b;
          acc_d = 32'd0;
          if (SKIP_ZERO && (a == 16'd0 || b == 16'd0)) begin
            product_d   = 32'd0;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            step_d  = 2'd0;
            state_d = MUL;
          end
        end
      end
      MUL: begin
        acc_d = acc_sum;
        if (step_q == 2'd3) begin
          product_d   = acc_sum;
          out_valid_d = 1'b1;
          step_d      = 2'd0;
          state_d     = DONE;
        end else begin
          step_d = step_q + 2'd1;
        end
      end
      DONE: begin
        // Accepting new operands waits for IDLE, so a handshake cycle never overlaps capture.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      step_q      <= 2'd0;
      a_q         <= 16'd0;
      b_q         <= 16'd0;
      acc_q       <= 32'd0;
      product_q   <= 32'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign product   = product_q;

endmodule

// File: tb/tb_vedic_mult_seq_ctrl.sv
// Directed bench for vedic_mult_seq_ctrl: two instances (zero bypass on/off)
// checked every cycle against a cycle-count/queue level model plus literals.
module tb_vedic_mult_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        iv   [2];
  logic [15:0] ia   [2];
  logic [15:0] ib   [2];
  logic        ordy [2];
  logic        irdy [2];
  logic        ov   [2];
  logic [31:0] prod [2];
  logic        bsy  [2];

  int n_vec = 0;
  int n_bad = 0;

  // Instance 0: every operation runs the full sequence. Instance 1: zero bypass.
  vedic_mult_seq_ctrl #(.SKIP_ZERO(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]), .a(ia[0]), .b(ib[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .product(prod[0]), .busy(bsy[0]));

  vedic_mult_seq_ctrl #(.SKIP_ZERO(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]), .a(ia[1]), .b(ib[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .product(prod[1]), .busy(bsy[1]));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: an accepted request is busy for a fixed number of edges, then shows a*b
  // until consumed; the result register holds its last value otherwise.
  bit          m_busy [2] = '{1'b0, 1'b0};
  bit          m_ov   [2] = '{1'b0, 1'b0};
  int          m_cnt  [2] = '{0, 0};
  logic [31:0] m_prod [2] = '{32'd0, 32'd0};
  logic [31:0] m_pend [2] = '{32'd0, 32'd0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] <= 1'b0;
        m_ov[i]   <= 1'b0;
        m_cnt[i]  <= 0;
        m_prod[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!m_busy[i]) begin
          if (iv[i]) begin
            m_busy[i] <= 1'b1;
            m_pend[i] <= 32'(ia[i]) * 32'(ib[i]);
            if (i == 1 && (ia[i] == 16'd0 || ib[i] == 16'd0)) begin
              m_ov[i]   <= 1'b1;
              m_prod[i] <= 32'd0;
            end else begin
              m_cnt[i] <= 4;
            end
          end
        end else if (m_ov[i]) begin
          if (ordy[i]) begin
            m_ov[i]   <= 1'b0;
            m_busy[i] <= 1'b0;
          end
        end else begin
          m_cnt[i] <= m_cnt[i] - 1;
          if (m_cnt[i] == 1) begin
            m_ov[i]   <= 1'b1;
            m_prod[i] <= m_pend[i];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("model in_ready[%0d]", i), {31'd0, irdy[i]}, {31'd0, !m_busy[i]});
      chk($sformatf("model busy[%0d]", i), {31'd0, bsy[i]}, {31'd0, m_busy[i]});
      chk($sformatf("model out_valid[%0d]", i), {31'd0, ov[i]}, {31'd0, m_ov[i]});
      chk($sformatf("model product[%0d]", i), prod[i], m_prod[i]);
    end
  end

  task automatic wait_ov(input int i, output int lat);
    lat = 0;
    while (!ov[i] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic op(input int i, input logic [15:0] av, input logic [15:0] bv, input int hold,
                    input logic [31:0] exp_p, input int exp_lat, input string name);
    int w;
    int lat;
    @(negedge clk);
    w = 0;
    while (!irdy[i] && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({name, " ready wait"}, w, 0);
    iv[i] = 1'b1; ia[i] = av; ib[i] = bv; ordy[i] = (hold == 0);
    @(negedge clk);
    iv[i] = 1'b0;
    wait_ov(i, lat);
    chk({name, " latency"}, lat, exp_lat);
    chk({name, " product"}, prod[i], exp_p);
    repeat (hold) @(negedge clk);
    chk({name, " held product"}, prod[i], exp_p);
    ordy[i] = 1'b1;
    @(negedge clk);
    chk({name, " in_ready after"}, {31'd0, irdy[i]}, 32'd1);
    chk({name, " out_valid after"}, {31'd0, ov[i]}, 32'd0);
  endtask

  initial begin
    int lat;
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; ia[i] = 16'd0; ib[i] = 16'd0; ordy[i] = 1'b1;
    end
    #2 rst = 1'b1;
    @(negedge clk);
    chk("reset out_valid", {31'd0, ov[1]}, 32'd0);
    chk("reset product", prod[1], 32'd0);
    chk("reset busy", {31'd0, bsy[1]}, 32'd0);
    chk("reset in_ready", {31'd0, irdy[1]}, 32'd1);
    rst = 1'b0;

    op(1, 16'hFFFF, 16'hFFFF, 0, 32'hFFFE0001, 4, "max");
    op(1, 16'h1234, 16'h5678, 0, 32'h06260060, 4, "mixed");
    op(1, 16'h5678, 16'h1234, 0, 32'h06260060, 4, "swapped");
    op(1, 16'h0000, 16'hABCD, 0, 32'h00000000, 0, "bypass");
    op(1, 16'h0007, 16'h0000, 2, 32'h00000000, 0, "bypass b0");
    op(0, 16'h0000, 16'hABCD, 0, 32'h00000000, 4, "noskip zero");
    op(0, 16'h00FF, 16'h0101, 1, 32'h0000FFFF, 4, "noskip small");

    // Backpressure with a competing request held during MUL and DONE
    @(negedge clk);
    iv[1] = 1'b1; ia[1] = 16'h00FF; ib[1] = 16'h0100; ordy[1] = 1'b0;
    @(negedge clk);
    ia[1] = 16'h1111; ib[1] = 16'h2222;
    wait_ov(1, lat);
    chk("bp latency", lat, 4);
    chk("bp product", prod[1], 32'h0000FF00);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp held product", prod[1], 32'h0000FF00);
      chk("bp in_ready low", {31'd0, irdy[1]}, 32'd0);
    end
    ordy[1] = 1'b1;
    @(negedge clk);
    chk("bp idle after handshake", {31'd0, irdy[1]}, 32'd1);
    @(negedge clk);
    iv[1] = 1'b0;
    chk("bp second captured", {31'd0, bsy[1]}, 32'd1);
    wait_ov(1, lat);
    chk("second latency", lat, 4);
    chk("second product", prod[1], 32'h02468642);
    @(negedge clk);

    // Reset during step 2
    @(negedge clk);
    iv[1] = 1'b1; ia[1] = 16'hFFFF; ib[1] = 16'hFFFF;
    @(negedge clk);
    iv[1] = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst mid out_valid", {31'd0, ov[1]}, 32'd0);
    chk("rst mid product", prod[1], 32'd0);
    chk("rst mid busy", {31'd0, bsy[1]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    op(1, 16'h0003, 16'h0005, 0, 32'h0000000F, 4, "after reset");

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
